// File: rtl/ccm_pkg.sv
// Shared constants, types and helpers for the colour-correction-matrix stage.
package ccm_pkg;

  localparam int COEF_W = 16;
  localparam int FRAC_W = 8;
  localparam int PROD_W = COEF_W + 9;
  localparam int SUM_W  = PROD_W + 2;
  localparam int OFF_W  = 10;

  localparam logic [3:0] ADDR_C_LAST = 4'd8;
  localparam logic [3:0] ADDR_OFF_R  = 4'd9;
  localparam logic [3:0] ADDR_OFF_G  = 4'd10;
  localparam logic [3:0] ADDR_OFF_B  = 4'd11;

  localparam logic [COEF_W-1:0] COEF_ONE  = COEF_W'(1 << FRAC_W);
  localparam logic [COEF_W-1:0] COEF_ZERO = '0;

  typedef logic [8:0][COEF_W-1:0] coef_set_t;

  // Index 0 is c00, index 8 is c22.
  localparam coef_set_t COEF_IDENT = {
    COEF_ONE, COEF_ZERO, COEF_ZERO, COEF_ZERO,
    COEF_ONE, COEF_ZERO, COEF_ZERO, COEF_ZERO,
    COEF_ONE
  };

  function automatic logic [7:0] clamp8(
    input logic signed [SUM_W:0] v
  );
    if (v < 0)
      return 8'd0;
    else if (v > 255)
      return 8'hff;
    else
      return v[7:0];
  endfunction

endpackage

// File: rtl/ccm_dot3.sv
// One matrix row: registered products, then registered sum with
// the rounding constant folded in.
module ccm_dot3 import ccm_pkg::*; (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               x0,
  input  logic [7:0]               x1,
  input  logic [7:0]               x2,
  input  logic signed [COEF_W-1:0] c0,
  input  logic signed [COEF_W-1:0] c1,
  input  logic signed [COEF_W-1:0] c2,
  output logic signed [SUM_W-1:0]  sum
);

  localparam logic signed [SUM_W-1:0] HALF =
    SUM_W'(1 << (FRAC_W - 1));

  logic signed [PROD_W-1:0] p0, p1, p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      p0  <= '0;
      p1  <= '0;
      p2  <= '0;
      sum <= '0;
    end else begin
      p0  <= PROD_W'($signed({1'b0, x0})) * PROD_W'(c0);
      p1  <= PROD_W'($signed({1'b0, x1})) * PROD_W'(c1);
      p2  <= PROD_W'($signed({1'b0, x2})) * PROD_W'(c2);
      sum <= SUM_W'(p0) + SUM_W'(p1) + SUM_W'(p2) + HALF;
    end
  end

endmodule

// File: rtl/ccm_top.sv
// Colour-correction matrix with frame-synchronous coefficient swap.
// Optional per-channel offsets are built when CCM_OFFSET_EN is defined.
module ccm_top import ccm_pkg::*; #(
  parameter int source_h = 1024,
  parameter int source_v = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_vsync,
  input  logic        in_hsync,
  input  logic        in_den,
  input  logic [7:0]  in_data_R,
  input  logic [7:0]  in_data_G,
  input  logic [7:0]  in_data_B,
  input  logic        cfg_wr,
  input  logic [3:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  input  logic        cfg_commit,
  output logic        cfg_pending,
  output logic        out_vsync,
  output logic        out_hsync,
  output logic        out_den,
  output logic [7:0]  out_data_R,
  output logic [7:0]  out_data_G,
  output logic [7:0]  out_data_B
);

  coef_set_t  stg_c, act_c;
  logic       vsync_q;
  logic       boundary;
  logic [2:0] tm_q1, tm_q2;
  logic [7:0] res [3];
  logic [7:0] pix [3];

`ifdef CCM_OFFSET_EN
  logic [2:0][OFF_W-1:0] stg_o, act_o;
  logic [2:0][OFF_W-1:0] off_q1, off_q2;
`endif

  assign boundary = in_vsync & ~vsync_q;
  assign pix[0]   = in_data_R;
  assign pix[1]   = in_data_G;
  assign pix[2]   = in_data_B;

  always_ff @(posedge clk) begin
    if (reset) begin
      stg_c       <= COEF_IDENT;
      act_c       <= COEF_IDENT;
      cfg_pending <= 1'b0;
      vsync_q     <= 1'b0;
`ifdef CCM_OFFSET_EN
      stg_o       <= '0;
      act_o       <= '0;
`endif
    end else begin
      vsync_q <= in_vsync;
      // Copy samples staging before this edge's write.
      if (boundary && (cfg_pending || cfg_commit)) begin
        act_c       <= stg_c;
`ifdef CCM_OFFSET_EN
        act_o       <= stg_o;
`endif
        cfg_pending <= 1'b0;
      end else if (cfg_commit) begin
        cfg_pending <= 1'b1;
      end
      if (cfg_wr) begin
        unique case (1'b1)
          cfg_addr <= ADDR_C_LAST:
            stg_c[cfg_addr] <= cfg_data;
`ifdef CCM_OFFSET_EN
          cfg_addr == ADDR_OFF_R:
            stg_o[0] <= cfg_data[OFF_W-1:0];
          cfg_addr == ADDR_OFF_G:
            stg_o[1] <= cfg_data[OFF_W-1:0];
          cfg_addr == ADDR_OFF_B:
            stg_o[2] <= cfg_data[OFF_W-1:0];
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tm_q1  <= '0;
      tm_q2  <= '0;
`ifdef CCM_OFFSET_EN
      off_q1 <= '0;
      off_q2 <= '0;
`endif
    end else begin
      tm_q1  <= {in_vsync, in_hsync, in_den};
      tm_q2  <= tm_q1;
`ifdef CCM_OFFSET_EN
      off_q1 <= act_o;
      off_q2 <= off_q1;
`endif
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_row
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W:0]   val;

    ccm_dot3 u_dot (
      .clk   (clk),
      .reset (reset),
      .x0    (pix[0]),
      .x1    (pix[1]),
      .x2    (pix[2]),
      .c0    ($signed(act_c[3*i])),
      .c1    ($signed(act_c[3*i+1])),
      .c2    ($signed(act_c[3*i+2])),
      .sum   (sum)
    );

`ifdef CCM_OFFSET_EN
    assign val = (SUM_W+1)'(sum >>> FRAC_W)
               + (SUM_W+1)'($signed(off_q2[i]));
`else
    assign val = (SUM_W+1)'(sum >>> FRAC_W);
`endif
    assign res[i] = clamp8(val);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_vsync  <= 1'b0;
      out_hsync  <= 1'b0;
      out_den    <= 1'b0;
      out_data_R <= '0;
      out_data_G <= '0;
      out_data_B <= '0;
    end else begin
      {out_vsync, out_hsync, out_den} <= tm_q2;
      out_data_R <= tm_q2[0] ? res[0] : 8'd0;
      out_data_G <= tm_q2[0] ? res[1] : 8'd0;
      out_data_B <= tm_q2[0] ? res[2] : 8'd0;
    end
  end

endmodule

// File: tb/tb_ccm_top.sv
// Bench for ccm_top: frame-level reference model compared every cycle,
// plus directed pixels with literal expected results.
module tb_ccm_top;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_vsync = 1'b0;
  logic        in_hsync = 1'b0;
  logic        in_den = 1'b0;
  logic [7:0]  in_data_R = '0;
  logic [7:0]  in_data_G = '0;
  logic [7:0]  in_data_B = '0;
  logic        cfg_wr = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        cfg_commit = 1'b0;
  logic        cfg_pending;
  logic        out_vsync, out_hsync, out_den;
  logic [7:0]  out_data_R, out_data_G, out_data_B;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ccm_top dut (
    .clk         (clk),
    .reset       (reset),
    .in_vsync    (in_vsync),
    .in_hsync    (in_hsync),
    .in_den      (in_den),
    .in_data_R   (in_data_R),
    .in_data_G   (in_data_G),
    .in_data_B   (in_data_B),
    .cfg_wr      (cfg_wr),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_commit  (cfg_commit),
    .cfg_pending (cfg_pending),
    .out_vsync   (out_vsync),
    .out_hsync   (out_hsync),
    .out_den     (out_den),
    .out_data_R  (out_data_R),
    .out_data_G  (out_data_G),
    .out_data_B  (out_data_B)
  );

  // Reference model: matrices as plain integers, outputs as a 3-deep queue.
  int          m_sc [9];
  int          m_ac [9];
  int          m_so [3];
  int          m_ao [3];
  bit          m_pend = 1'b0;
  bit          m_vq = 1'b0;
  bit          m_valid = 1'b0;
  logic [26:0] m_pipe [3];

  function automatic logic [7:0] sat(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  always @(posedge clk) begin : model
    int x [3];
    int acc;
    logic [23:0] px;
    if (reset) begin
      for (int k = 0; k < 9; k++) begin
        m_sc[k] = (k % 4 == 0) ? 256 : 0;
        m_ac[k] = m_sc[k];
      end
      for (int k = 0; k < 3; k++) begin
        m_so[k] = 0;
        m_ao[k] = 0;
        m_pipe[k] = '0;
      end
      m_pend  = 1'b0;
      m_vq    = 1'b0;
      m_valid = 1'b1;
    end else begin
      x[0] = int'(in_data_R);
      x[1] = int'(in_data_G);
      x[2] = int'(in_data_B);
      px = '0;
      if (in_den) begin
        for (int i = 0; i < 3; i++) begin
          acc = 128;
          for (int j = 0; j < 3; j++)
            acc += m_ac[3*i+j] * x[j];
          px[23-8*i -: 8] = sat((acc >>> 8) + m_ao[i]);
        end
      end
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = {in_vsync, in_hsync, in_den, px};
      if (in_vsync && !m_vq && (m_pend || cfg_commit)) begin
        m_ac = m_sc;
        m_ao = m_so;
        m_pend = 1'b0;
      end else if (cfg_commit) begin
        m_pend = 1'b1;
      end
      if (cfg_wr) begin
        if (cfg_addr < 4'd9)
          m_sc[cfg_addr] = int'($signed(cfg_data));
`ifdef CCM_OFFSET_EN
        else if (cfg_addr < 4'd12)
          m_so[cfg_addr-4'd9] = int'($signed(cfg_data[9:0]));
`endif
      end
      m_vq = in_vsync;
    end
  end

  always @(negedge clk) begin : compare
    logic [26:0] got;
    if (m_valid) begin
      got = {out_vsync, out_hsync, out_den,
             out_data_R, out_data_G, out_data_B};
      total++;
      if (got === m_pipe[2] && cfg_pending === m_pend)
        passed++;
      else
        $display("FAIL model t=%0t: got %h pend %b, need %h pend %b",
                 $time, got, cfg_pending, m_pipe[2], m_pend);
    end
  end

  task automatic lit(input string name, input int got, input int exp);
    total++;
    if (got == exp)
      passed++;
    else
      $display("FAIL %s: got %0d, need %0d", name, got, exp);
  endtask

  task automatic clr();
    in_vsync   = 1'b0;
    in_hsync   = 1'b0;
    in_den     = 1'b0;
    in_data_R  = '0;
    in_data_G  = '0;
    in_data_B  = '0;
    cfg_wr     = 1'b0;
    cfg_addr   = '0;
    cfg_data   = '0;
    cfg_commit = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      clr();
      @(negedge clk);
    end
  endtask

  task automatic set_pix(input int r, input int g, input int b);
    in_den    = 1'b1;
    in_hsync  = 1'b1;
    in_data_R = 8'(r);
    in_data_G = 8'(g);
    in_data_B = 8'(b);
  endtask

  task automatic pix(input int r, input int g, input int b);
    clr();
    set_pix(r, g, b);
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    clr();
    cfg_wr   = 1'b1;
    cfg_addr = 4'(a);
    cfg_data = 16'(d);
    @(negedge clk);
  endtask

  task automatic commit();
    clr();
    cfg_commit = 1'b1;
    @(negedge clk);
  endtask

  task automatic vs_pulse();
    clr();
    in_vsync = 1'b1;
    @(negedge clk);
  endtask

  task automatic apply();
    commit();
    vs_pulse();
  endtask

  task automatic chk_rgb(input string n, input int r, input int g,
                         input int b);
    lit({n, ".R"}, int'(out_data_R), r);
    lit({n, ".G"}, int'(out_data_G), g);
    lit({n, ".B"}, int'(out_data_B), b);
  endtask

  task automatic pix_chk(input string n,
                         input int r, input int g, input int b,
                         input int er, input int eg, input int eb);
    pix(r, g, b);
    idle(2);
    chk_rgb(n, er, eg, eb);
  endtask

  initial begin : stim
    int swap [9];
    swap = '{0, 256, 0, 256, 0, 0, 0, 0, 256};
    clr();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    lit("rst.pending", int'(cfg_pending), 0);
    lit("rst.den", int'(out_den), 0);
    chk_rgb("rst", 0, 0, 0);
    reset = 1'b0;

    // Identity and 3-cycle latency.
    pix(100, 150, 200);
    idle(1);
    lit("lat2.den", int'(out_den), 0);
    idle(1);
    lit("lat3.den", int'(out_den), 1);
    lit("lat3.hsync", int'(out_hsync), 1);
    chk_rgb("ident", 100, 150, 200);

    // Channel swap only after the boundary.
    for (int k = 0; k < 9; k++) wr(k, swap[k]);
    commit();
    lit("swap.pending", int'(cfg_pending), 1);
    pix_chk("preswap", 10, 20, 30, 10, 20, 30);
    vs_pulse();
    lit("swap.cleared", int'(cfg_pending), 0);
    idle(2);
    lit("vsync.lat3", int'(out_vsync), 1);
    pix_chk("swap", 10, 20, 30, 20, 10, 30);

    // Saturation, both ends.
    wr(0, 512); wr(1, 0); wr(3, 0); wr(4, 256);
    apply();
    pix_chk("sat.hi", 200, 0, 0, 255, 0, 0);
    wr(0, 16'hff00);
    apply();
    pix_chk("sat.lo", 50, 7, 9, 0, 7, 9);

    // Rounding half-up.
    wr(0, 128);
    apply();
    pix_chk("round3", 3, 0, 0, 2, 0, 0);
    pix_chk("round1", 1, 0, 0, 1, 0, 0);

    // Commit and write in the boundary cycle itself.
    wr(0, 256);
    clr();
    in_vsync   = 1'b1;
    cfg_commit = 1'b1;
    cfg_wr     = 1'b1;
    cfg_addr   = 4'd4;
    cfg_data   = 16'd0;
    set_pix(3, 100, 7);
    @(negedge clk);
    lit("coll.pending1", int'(cfg_pending), 0);
    pix(3, 100, 7);
    lit("coll.pending2", int'(cfg_pending), 0);
    idle(1);
    chk_rgb("coll.old", 2, 100, 7);
    idle(1);
    chk_rgb("coll.new", 3, 100, 7);
    apply();
    pix_chk("coll.stg", 3, 100, 7, 3, 0, 7);

    // Offsets; ignored writes when the feature is absent.
    wr(4, 256);
    wr(9, 16'h03f6);
    wr(10, 20);
    wr(12, 16'h1234);
    apply();
`ifdef CCM_OFFSET_EN
    pix_chk("off.clamp", 5, 250, 0, 0, 255, 0);
    pix_chk("off.mid", 100, 100, 100, 90, 120, 100);
`else
    pix_chk("off.clamp", 5, 250, 0, 5, 250, 0);
    pix_chk("off.mid", 100, 100, 100, 100, 100, 100);
`endif

    // Reset mid-frame with pixels in flight and a pending commit.
    wr(0, 512);
    apply();
    commit();
    pix(100, 0, 0);
    pix(100, 0, 0);
    clr();
    set_pix(100, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    lit("mid.pending", int'(cfg_pending), 0);
    lit("mid.den", int'(out_den), 0);
    chk_rgb("mid.zero", 0, 0, 0);
    pix_chk("mid.ident", 100, 150, 200, 100, 150, 200);
    wr(0, 512);
    apply();
    pix_chk("mid.bound", 100, 0, 0, 200, 0, 0);

    idle(4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
